// File: rtl/armleocpu_tlb_asid.sv
// Set-associative, ASID-tagged TLB for Sv32 leaf translations with per-set
// round-robin replacement and SFENCE.VMA-style selective flushes.
module armleocpu_tlb_asid #(
  parameter int ENTRIES_W = 1,
  parameter int WAYS      = 3,
  parameter int ASID_W    = 9,
  localparam int WAYS_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmd,
  input  logic [19:0]       vaddr_input,
  input  logic [ASID_W-1:0] asid_input,
  input  logic [7:0]        new_entry_metadata_input,
  input  logic [21:0]       new_entry_ptag_input,
  output logic              busy,
  output logic              hit,
  output logic [7:0]        resolve_metadata_output,
  output logic [21:0]       resolve_ptag_output,
  output logic [WAYS_W-1:0] resolve_way
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int TAG_W = 20 - ENTRIES_W;

  localparam logic [2:0] CMD_RESOLVE   = 3'd1;
  localparam logic [2:0] CMD_NEW_ENTRY = 3'd2;
  localparam logic [2:0] CMD_INV_ALL   = 3'd3;
  localparam logic [2:0] CMD_INV_VADDR = 3'd4;
  localparam logic [2:0] CMD_INV_ASID  = 3'd5;

  typedef enum logic {IDLE, WALK} state_t;

  state_t state_q, state_d;
  logic [ENTRIES_W-1:0] walkSet_q, walkSet_d;
  logic [ASID_W-1:0]    walkAsid_q, walkAsid_d;

  logic              valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [ASID_W-1:0] asid_q   [SETS][WAYS];
  logic [7:0]        meta_q   [SETS][WAYS];
  logic [21:0]       ptag_q   [SETS][WAYS];
  logic [WAYS_W-1:0] victim_q [SETS];

  logic              hit_q;
  logic [7:0]        resMeta_q;
  logic [21:0]       resPtag_q;
  logic [WAYS_W-1:0] resWay_q;

  logic                 accept;
  logic [ENTRIES_W-1:0] cmdSet;
  logic [TAG_W-1:0]     cmdTag;
  logic                 matchHit;
  logic [WAYS_W-1:0]    matchWay;

  assign accept = (state_q == IDLE);
  assign cmdSet = vaddr_input[ENTRIES_W-1:0];
  assign cmdTag = vaddr_input[19:ENTRIES_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      walkSet_q  <= '0;
      walkAsid_q <= '0;
    end else begin
      state_q    <= state_d;
      walkSet_q  <= walkSet_d;
      walkAsid_q <= walkAsid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    walkSet_d  = walkSet_q;
    walkAsid_d = walkAsid_q;
    case (state_q)
      IDLE: if (cmd == CMD_INV_ASID) begin
        state_d    = WALK;
        walkSet_d  = '0;
        walkAsid_d = asid_input;
      end
      WALK: begin
        if (walkSet_q == ENTRIES_W'(SETS - 1)) state_d = IDLE;
        else walkSet_d = walkSet_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == WALK);
  end

  // Descending scan so the lowest matching way is the one that sticks.
  always_comb begin
    matchHit = 1'b0;
    matchWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[cmdSet][w] && (tag_q[cmdSet][w] == cmdTag) &&
          (meta_q[cmdSet][w][5] || (asid_q[cmdSet][w] == asid_input))) begin
        matchHit = 1'b1;
        matchWay = WAYS_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        victim_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (state_q == WALK) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[walkSet_q][w] && !meta_q[walkSet_q][w][5] &&
            (asid_q[walkSet_q][w] == walkAsid_q))
          valid_q[walkSet_q][w] <= 1'b0;
      end
    end else begin
      case (cmd)
        CMD_NEW_ENTRY: begin
          valid_q[cmdSet][victim_q[cmdSet]] <= 1'b1;
          victim_q[cmdSet] <= (victim_q[cmdSet] == WAYS_W'(WAYS - 1)) ? '0
                              : victim_q[cmdSet] + 1'b1;
        end
        CMD_INV_ALL: begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
        CMD_INV_VADDR: begin
          for (int w = 0; w < WAYS; w++)
            if (tag_q[cmdSet][w] == cmdTag) valid_q[cmdSet][w] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Entry payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (accept && (cmd == CMD_NEW_ENTRY)) begin
      tag_q[cmdSet][victim_q[cmdSet]]  <= cmdTag;
      asid_q[cmdSet][victim_q[cmdSet]] <= asid_input;
      meta_q[cmdSet][victim_q[cmdSet]] <= new_entry_metadata_input;
      ptag_q[cmdSet][victim_q[cmdSet]] <= new_entry_ptag_input;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= 1'b0;
      resMeta_q <= '0;
      resPtag_q <= '0;
      resWay_q  <= '0;
    end else if (accept && (cmd == CMD_RESOLVE)) begin
      hit_q     <= matchHit;
      resMeta_q <= matchHit ? meta_q[cmdSet][matchWay] : 8'h00;
      resPtag_q <= matchHit ? ptag_q[cmdSet][matchWay] : 22'h0;
      resWay_q  <= matchWay;
    end
  end

  assign hit                     = hit_q;
  assign resolve_metadata_output = resMeta_q;
  assign resolve_ptag_output     = resPtag_q;
  assign resolve_way             = resWay_q;

endmodule
